// File: rtl/seq_arith_unit_if.sv
// Handshake and operand/result bundle between a sequencer (master) and seq_arith_unit (slave).
interface seq_arith_unit_if #(
  parameter int k = 16
);
  logic         start;
  logic [1:0]   mode;
  logic [k-1:0] A;
  logic [k-1:0] B;
  logic         ready;
  logic         done;
  logic [k-1:0] C;
  logic [k-1:0] D;
  logic [1:0]   StatusSignals;

  modport master (
    output start, mode, A, B,
    input  ready, done, C, D, StatusSignals
  );

  modport slave (
    input  start, mode, A, B,
    output ready, done, C, D, StatusSignals
  );
endinterface

// File: rtl/seq_arith_unit.sv
// Multi-cycle GCD / multiply / divide unit with its own IDLE-RUN-DONE controller.
// Results are loaded on entry to DONE and held until the next completed operation.
module seq_arith_unit #(
  parameter int k = 16
) (
  input logic             clk,
  input logic             reset,
  seq_arith_unit_if.slave bus
);
  localparam int CW = $clog2(k + 1);
  localparam logic [1:0] ModeGcd = 2'b00;
  localparam logic [1:0] ModeMul = 2'b01;
  localparam logic [1:0] ModeDiv = 2'b10;
  localparam logic [1:0] ModeRsv = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT        state;
  logic [k-1:0] a, b, hi;
  logic [1:0]   m;
  logic [CW-1:0] cnt;

  logic [k:0]   mulSum, divShift, divTrial;
  logic         divOk, lastStep, gcdFinish, runFinish;
  logic [k-1:0] gcdVal, resC, resD;

  // One iteration of the active algorithm. For MUL {hi,b} shifts right as the
  // product forms; for DIV hi is the partial remainder and a collects quotient bits.
  always_comb begin
    mulSum    = {1'b0, hi} + (b[0] ? {1'b0, a} : '0);
    divShift  = {hi, a[k-1]};
    divTrial  = divShift - {1'b0, b};
    divOk     = ~divTrial[k];
    lastStep  = (cnt == CW'(k - 1));
    gcdFinish = (a == b) || (a == '0) || (b == '0);
    gcdVal    = (a == '0) ? b : a;
    runFinish = 1'b0;
    resC      = '0;
    resD      = '0;
    case (m)
      ModeGcd: begin
        runFinish = gcdFinish;
        resC      = gcdVal;
      end
      ModeMul: begin
        runFinish = lastStep;
        resD      = mulSum[k:1];
        resC      = {mulSum[0], b[k-1:1]};
      end
      ModeDiv: begin
        runFinish = lastStep;
        resD      = divOk ? divTrial[k-1:0] : divShift[k-1:0];
        resC      = {a[k-2:0], divOk};
      end
      default: runFinish = 1'b1;
    endcase
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      a                 <= '0;
      b                 <= '0;
      hi                <= '0;
      m                 <= '0;
      cnt               <= '0;
      bus.C             <= '0;
      bus.D             <= '0;
      bus.StatusSignals <= '0;
      bus.done          <= 1'b0;
      bus.ready         <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a         <= bus.A;
            b         <= bus.B;
            m         <= bus.mode;
            hi        <= '0;
            cnt       <= '0;
            bus.ready <= 1'b0;
            if (bus.mode == ModeRsv) begin
              bus.C             <= '0;
              bus.D             <= '0;
              bus.StatusSignals <= 2'b11;
              bus.done          <= 1'b1;
              state             <= DONE;
            end else if (bus.mode == ModeDiv && bus.B == '0) begin
              // C is all-ones, so {D,C} can never be zero here
              bus.C             <= '1;
              bus.D             <= bus.A;
              bus.StatusSignals <= 2'b10;
              bus.done          <= 1'b1;
              state             <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          case (m)
            ModeGcd: begin
              if (!gcdFinish) begin
                if (a > b) begin
                  a <= a - b;
                end else begin
                  b <= b - a;
                end
              end
            end
            ModeMul: begin
              hi  <= resD;
              b   <= resC;
              cnt <= cnt + CW'(1);
            end
            ModeDiv: begin
              hi  <= resD;
              a   <= resC;
              cnt <= cnt + CW'(1);
            end
            default: ;
          endcase
          if (runFinish) begin
            bus.C             <= resC;
            bus.D             <= resD;
            bus.StatusSignals <= {m == ModeRsv, {resD, resC} == '0};
            bus.done          <= 1'b1;
            state             <= DONE;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit: an operation-level model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_seq_arith_unit;
  localparam int K = 16;

  logic clk;
  logic reset;
  int   nTests = 0;
  int   nFail  = 0;
  bit   checkEn = 1'b0;

  seq_arith_unit_if #(.k(K)) bus ();

  seq_arith_unit #(.k(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: what the outputs must be, derived from operation results and latencies.
  logic         expReady = 1'b1;
  logic         expDone  = 1'b0;
  logic [K-1:0] expC = '0, expD = '0;
  logic [1:0]   expS = '0;
  logic         mBusy = 1'b0;
  int           mLeft = 0;
  logic [K-1:0] pC, pD;
  logic [1:0]   pS;
  int           pLat;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelOp(input logic [1:0] md, input logic [K-1:0] x, input logic [K-1:0] y,
                                  output logic [K-1:0] c, output logic [K-1:0] d,
                                  output logic [1:0] s, output int lat);
    logic [2*K-1:0] p;
    logic [K-1:0]   u, v;
    logic           err;
    err = 1'b0;
    c   = '0;
    d   = '0;
    lat = 0;
    case (md)
      2'b00: begin
        u   = x;
        v   = y;
        lat = 1;
        while (!(u == v || u == '0 || v == '0)) begin
          if (u > v) u = u - v;
          else       v = v - u;
          lat++;
        end
        c = (u == '0) ? v : u;
      end
      2'b01: begin
        p   = (2*K)'(x) * (2*K)'(y);
        c   = p[K-1:0];
        d   = p[2*K-1:K];
        lat = K;
      end
      2'b10: begin
        if (y == '0) begin
          c   = '1;
          d   = x;
          err = 1'b1;
        end else begin
          c   = x / y;
          d   = x % y;
          lat = K;
        end
      end
      default: err = 1'b1;
    endcase
    s = {err, ({d, c} == '0)};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      expReady = 1'b1;
      expDone  = 1'b0;
      expC     = '0;
      expD     = '0;
      expS     = '0;
      mBusy    = 1'b0;
    end else if (expDone) begin
      expDone  = 1'b0;
      expReady = 1'b1;
    end else if (mBusy) begin
      mLeft--;
      if (mLeft == 0) begin
        mBusy   = 1'b0;
        expDone = 1'b1;
        expC    = pC;
        expD    = pD;
        expS    = pS;
      end
    end else if (expReady && bus.start) begin
      modelOp(bus.mode, bus.A, bus.B, pC, pD, pS, pLat);
      expReady = 1'b0;
      if (pLat == 0) begin
        expDone = 1'b1;
        expC    = pC;
        expD    = pD;
        expS    = pS;
      end else begin
        mBusy = 1'b1;
        mLeft = pLat;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model ready", 32'(bus.ready), 32'(expReady));
      checkOutput("model done", 32'(bus.done), 32'(expDone));
      checkOutput("model C", 32'(bus.C), 32'(expC));
      checkOutput("model D", 32'(bus.D), 32'(expD));
      checkOutput("model status", 32'(bus.StatusSignals), 32'(expS));
    end
  end

  task automatic applyStimulus(input logic [1:0] md, input logic [K-1:0] x, input logic [K-1:0] y);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) checkOutput("ready wait", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.mode  = md;
    bus.A     = x;
    bus.B     = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] md, input logic [K-1:0] x,
                       input logic [K-1:0] y, input logic [K-1:0] eC, input logic [K-1:0] eD,
                       input logic [1:0] eS, input int eLat);
    int lat;
    applyStimulus(md, x, y);
    waitDone(lat);
    checkOutput({name, " latency"}, lat, eLat);
    checkOutput({name, " C"}, 32'(bus.C), 32'(eC));
    checkOutput({name, " D"}, 32'(bus.D), 32'(eD));
    checkOutput({name, " status"}, 32'(bus.StatusSignals), 32'(eS));
  endtask

  initial begin
    int lat;
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    bus.A     = 16'd5;
    bus.B     = 16'd5;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset ready", 32'(bus.ready), 32'd1);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset C", 32'(bus.C), 32'd0);
    checkOutput("reset D", 32'(bus.D), 32'd0);
    checkOutput("reset status", 32'(bus.StatusSignals), 32'd0);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    checkOutput("no accept after reset", 32'(bus.ready), 32'd1);

    runOp("mul max",   2'b01, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 2'b00, 16);
    runOp("mul zero",  2'b01, 16'd0,    16'd1234, 16'd0,    16'd0,    2'b01, 16);
    runOp("div",       2'b10, 16'd1000, 16'd7,    16'd142,  16'd6,    2'b00, 16);
    runOp("div by 0",  2'b10, 16'd5,    16'd0,    16'hFFFF, 16'd5,    2'b10, 0);
    runOp("reserved",  2'b11, 16'd7,    16'd9,    16'd0,    16'd0,    2'b11, 0);
    runOp("gcd 12 18", 2'b00, 16'd12,   16'd18,   16'd6,    16'd0,    2'b00, 3);
    runOp("gcd 9 9",   2'b00, 16'd9,    16'd9,    16'd9,    16'd0,    2'b00, 1);
    runOp("gcd 0 0",   2'b00, 16'd0,    16'd0,    16'd0,    16'd0,    2'b01, 1);
    runOp("gcd 0 5",   2'b00, 16'd0,    16'd5,    16'd5,    16'd0,    2'b00, 1);

    // New operands pulsed mid-operation must not disturb the running multiply.
    applyStimulus(2'b01, 16'd3, 16'd5);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'b00;
    bus.A     = 16'd100;
    bus.B     = 16'd100;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(lat);
    checkOutput("ignored start C", 32'(bus.C), 32'd15);
    checkOutput("ignored start D", 32'(bus.D), 32'd0);

    // Back-to-back multiplies with start held high.
    applyStimulus(2'b01, 16'd100, 16'd200);
    bus.start = 1'b1;
    waitDone(lat);
    checkOutput("b2b first C", 32'(bus.C), 32'd20000);
    bus.A = 16'd3;
    bus.B = 16'd7;
    @(negedge clk);
    checkOutput("b2b idle ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    checkOutput("b2b accepted", 32'(bus.ready), 32'd0);
    bus.start = 1'b0;
    waitDone(lat);
    checkOutput("b2b second latency", lat, 16);
    checkOutput("b2b second C", 32'(bus.C), 32'd21);

    // Reset in the middle of a multiply aborts it silently.
    applyStimulus(2'b01, 16'h1234, 16'h5678);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort ready", 32'(bus.ready), 32'd1);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    checkOutput("abort C", 32'(bus.C), 32'd0);
    checkOutput("abort D", 32'(bus.D), 32'd0);
    reset = 1'b1;
    lat = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) lat++;
    end
    checkOutput("abort no done", lat, 0);
    runOp("div after abort", 2'b10, 16'd50000, 16'd123, 16'd406, 16'd62, 2'b00, 16);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
